// File: rtl/piso_shift_serializer.sv
// piso_shift_serializer
//   Parallel-in / serial-out shift register. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out one bit per clock, MSB-first or LSB-first
//   as selected per word. Back-to-back words stream with no gap.
//
//   Optional feature macro: PISO_SHIFT_SERIALIZER_PARITY_EN
//     defined   -> frame = WIDTH data bits + one even-parity bit (N = WIDTH+1)
//     undefined -> frame = WIDTH data bits (N = WIDTH), no parity logic
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  producer offers load_data
//   load_ready  block can accept a word this cycle (combinational)
//   load_data   parallel word to serialize
//   msb_first   direction, sampled with load_data (1 = MSB first)
//   ser_out     current serial bit (registered)
//   ser_valid   ser_out carries a frame bit (registered)
//   ser_last    ser_out is the final frame bit (registered)
//   busy        frame in progress (registered)
module piso_shift_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             msb_first,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

`ifdef PISO_SHIFT_SERIALIZER_PARITY_EN
   localparam int unsigned FLEN = WIDTH + 1;
`else
   localparam int unsigned FLEN = WIDTH;
`endif
   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LOAD = CW'(FLEN);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e          state;
   logic [FLEN-1:0] sreg;
   logic [CW-1:0]   cnt;   // bits remaining, including the one on ser_out
   logic            dir;
   logic [FLEN-1:0] frame;
   logic            accept;

   // Full frame in transmit order: the parity bit sits just past the data bit
   // that leaves last, so it follows the data in either direction.
   always_comb begin
`ifdef PISO_SHIFT_SERIALIZER_PARITY_EN
      if (msb_first) begin
         frame = {load_data, ^load_data};
      end else begin
         frame = {^load_data, load_data};
      end
`else
      frame = load_data;
`endif
   end

   assign load_ready = (state == StIdle) || ((state == StShift) && (cnt == CNT_ONE));
   assign accept     = load_valid && load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         sreg      <= '0;
         cnt       <= '0;
         dir       <= 1'b0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (accept) begin
         // First bit goes straight to ser_out; the register keeps the rest.
         state     <= StShift;
         dir       <= msb_first;
         cnt       <= CNT_LOAD;
         ser_valid <= 1'b1;
         ser_last  <= 1'b0;
         busy      <= 1'b1;
         if (msb_first) begin
            ser_out <= frame[FLEN-1];
            sreg    <= frame << 1;
         end else begin
            ser_out <= frame[0];
            sreg    <= frame >> 1;
         end
      end else if (state == StShift) begin
         if (cnt == CNT_ONE) begin
            state     <= StIdle;
            cnt       <= '0;
            sreg      <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
         end else begin
            cnt      <= cnt - CNT_ONE;
            ser_last <= (cnt == CNT_TWO);
            if (dir) begin
               ser_out <= sreg[FLEN-1];
               sreg    <= sreg << 1;
            end else begin
               ser_out <= sreg[0];
               sreg    <= sreg >> 1;
            end
         end
      end
   end

endmodule
